// File: rtl/vend_coin_scheduler.sv
// vend_coin_scheduler: two-slot coin buffer with round-robin feed into the
// vending FSM, credit/stock tracking, and refund diversion while sold out.
module vend_coin_scheduler #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned PRICE      = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_a_half,
  input  logic       pi_a_one,
  input  logic       pi_b_half,
  input  logic       pi_b_one,
  input  logic       pi_refill,
  output logic       po_money_half,
  output logic       po_money_one,
  output logic       po_refund_half,
  output logic       po_refund_one,
  output logic       po_src,
  output logic       po_err,
  output logic [2:0] po_credit,
  output logic [7:0] po_stock,
  output logic       po_sold_out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NS = 2;

  typedef enum logic {
    ST_VEND   = 1'b0,
    ST_REFUND = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Per-slot FIFO storage; index 0 is slot A, index 1 is slot B.
  logic [DEPTH-1:0] mem_q [NS];
  logic [AW-1:0]    wp_q  [NS];
  logic [AW-1:0]    rp_q  [NS];
  logic [CW-1:0]    cnt_q [NS];

  logic [NS-1:0] coin_half, coin_one, coin_vld, coin_bad;
  logic [NS-1:0] nonempty, full, push, pop, drop;
  logic          pop_vld, serve, head;

  logic       last_q, last_d;
  logic       src_q, src_d;
  logic [2:0] credit_q, credit_d;
  logic [7:0] stock_q, stock_d;
  logic       money_half_q, money_half_d;
  logic       money_one_q, money_one_d;
  logic       refund_half_q, refund_half_d;
  logic       refund_one_q, refund_one_d;
  logic       err_q, err_d;
  logic       sold_out_q, sold_out_d;
  logic       sale;
  logic [3:0] credit_sum;

  assign coin_half = {pi_b_half, pi_a_half};
  assign coin_one  = {pi_b_one, pi_a_one};
  assign coin_vld  = coin_half ^ coin_one;
  assign coin_bad  = coin_half & coin_one;

  // FIFO occupancy flags.
  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int s = 0; s < NS; s++) begin
      nonempty[s] = (cnt_q[s] != '0);
      full[s]     = (cnt_q[s] == CW'(DEPTH));
    end
  end

  // Round-robin pick: favour the slot not served last when both have coins.
  assign pop_vld = |nonempty;
  assign serve   = (&nonempty) ? ~last_q : nonempty[1];
  assign pop     = pop_vld ? (serve ? 2'b10 : 2'b01) : 2'b00;
  assign drop    = coin_vld & full & ~pop;
  assign push    = coin_vld & ~drop;
  assign head    = mem_q[serve][rp_q[serve]];

  // FIFO write/read pointers and occupancy counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int s = 0; s < NS; s++) begin
        mem_q[s] <= '0;
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (push[s]) begin
          mem_q[s][wp_q[s]] <= coin_one[s];
          wp_q[s]           <= wp_q[s] + AW'(1);
        end
        if (pop[s]) begin
          rp_q[s] <= rp_q[s] + AW'(1);
        end
        if (push[s] && !pop[s]) begin
          cnt_q[s] <= cnt_q[s] + CW'(1);
        end else if (!push[s] && pop[s]) begin
          cnt_q[s] <= cnt_q[s] - CW'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_VEND;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, credit/stock update and output routing of the popped coin.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    last_d        = last_q;
    src_d         = src_q;
    money_half_d  = 1'b0;
    money_one_d   = 1'b0;
    refund_half_d = 1'b0;
    refund_one_d  = 1'b0;
    err_d         = |(coin_bad | drop);
    sale          = 1'b0;
    credit_sum    = {1'b0, credit_q} + (head ? 4'd2 : 4'd1);

    if (pop_vld) begin
      last_d = serve;
      src_d  = serve;
      if (state_q == ST_VEND) begin
        money_half_d = ~head;
        money_one_d  = head;
        if (credit_sum >= 4'(PRICE)) begin
          sale     = 1'b1;
          credit_d = '0;
        end else begin
          credit_d = credit_sum[2:0];
        end
      end else begin
        refund_half_d = ~head;
        refund_one_d  = head;
      end
    end

    if (sale && pi_refill) begin
      stock_d = 8'(STOCK_INIT - 1);
    end else if (sale) begin
      stock_d = stock_q - 8'd1;
      if (stock_q == 8'd1) begin
        state_d = ST_REFUND;
      end
    end else if (pi_refill) begin
      stock_d = 8'(STOCK_INIT);
      state_d = ST_VEND;
    end

    sold_out_d = (state_d == ST_REFUND);
  end

  // Registered outputs and bookkeeping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_q        <= 1'b1;
      src_q         <= 1'b0;
      credit_q      <= '0;
      stock_q       <= 8'(STOCK_INIT);
      money_half_q  <= 1'b0;
      money_one_q   <= 1'b0;
      refund_half_q <= 1'b0;
      refund_one_q  <= 1'b0;
      err_q         <= 1'b0;
      sold_out_q    <= 1'b0;
    end else begin
      last_q        <= last_d;
      src_q         <= src_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      money_half_q  <= money_half_d;
      money_one_q   <= money_one_d;
      refund_half_q <= refund_half_d;
      refund_one_q  <= refund_one_d;
      err_q         <= err_d;
      sold_out_q    <= sold_out_d;
    end
  end

  assign po_money_half  = money_half_q;
  assign po_money_one   = money_one_q;
  assign po_refund_half = refund_half_q;
  assign po_refund_one  = refund_one_q;
  assign po_src         = src_q;
  assign po_err         = err_q;
  assign po_credit      = credit_q;
  assign po_stock       = stock_q;
  assign po_sold_out    = sold_out_q;

endmodule

// File: tb/tb_vend_coin_scheduler.sv
// Directed bench for vend_coin_scheduler with hand-computed expectations.
module tb_vend_coin_scheduler;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pi_a_half, pi_a_one, pi_b_half, pi_b_one, pi_refill;
  logic       po_money_half, po_money_one, po_refund_half, po_refund_one;
  logic       po_src, po_err, po_sold_out;
  logic [2:0] po_credit;
  logic [7:0] po_stock;

  int total = 0;
  int bad   = 0;

  int cred_t [8] = '{1, 3, 4, 0, 1, 3, 4, 0};
  int stk_t  [8] = '{8, 8, 8, 7, 7, 7, 7, 6};

  vend_coin_scheduler #(.DEPTH(4), .STOCK_INIT(8), .PRICE(5)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .pi_a_half      (pi_a_half),
    .pi_a_one       (pi_a_one),
    .pi_b_half      (pi_b_half),
    .pi_b_one       (pi_b_one),
    .pi_refill      (pi_refill),
    .po_money_half  (po_money_half),
    .po_money_one   (po_money_one),
    .po_refund_half (po_refund_half),
    .po_refund_one  (po_refund_one),
    .po_src         (po_src),
    .po_err         (po_err),
    .po_credit      (po_credit),
    .po_stock       (po_stock),
    .po_sold_out    (po_sold_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic ah, input logic ao, input logic bh, input logic bo,
                     input logic rf);
    pi_a_half = ah;
    pi_a_one  = ao;
    pi_b_half = bh;
    pi_b_one  = bo;
    pi_refill = rf;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0);
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  function automatic int n_out();
    return 32'(po_money_half) + 32'(po_money_one) + 32'(po_refund_half) + 32'(po_refund_one);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nm, ne, nr, multi;

    // Reset state and single A one-yuan coin.
    do_reset();
    chk("rst_outs", n_out(), 0);
    chk("rst_err", po_err, 0);
    chk("rst_src", po_src, 0);
    chk("rst_credit", po_credit, 0);
    chk("rst_stock", po_stock, 8);
    chk("rst_sold", po_sold_out, 0);
    drv(0, 1, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("t1_c1_outs", n_out(), 0);
    tick();
    chk("t1_c2_one", po_money_one, 1);
    chk("t1_c2_outs", n_out(), 1);
    chk("t1_c2_src", po_src, 0);
    chk("t1_c2_credit", po_credit, 2);
    chk("t1_c2_stock", po_stock, 8);
    tick();
    chk("t1_c3_outs", n_out(), 0);

    // Both slots together: alternating A-half / B-one.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c >= 2 && c <= 9) begin
        chk("t2_half", po_money_half, ((c - 2) % 2 == 0));
        chk("t2_one", po_money_one, ((c - 2) % 2));
        chk("t2_outs", n_out(), 1);
        chk("t2_src", po_src, ((c - 2) % 2));
        chk("t2_credit", po_credit, cred_t[c-2]);
        chk("t2_stock", po_stock, stk_t[c-2]);
      end else begin
        chk("t2_idle", n_out(), 0);
      end
      chk("t2_err", po_err, 0);
      drv((c < 4), 1'b0, 1'b0, (c < 4), 1'b0);
      tick();
    end

    // Illegal half+one on slot A.
    do_reset();
    drv(1, 1, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("t4_err", po_err, 1);
    chk("t4_outs1", n_out(), 0);
    tick();
    chk("t4_err_clr", po_err, 0);
    chk("t4_outs2", n_out(), 0);
    tick();
    chk("t4_outs3", n_out(), 0);

    // Overflow: both slots push a one every cycle for 12 cycles.
    do_reset();
    nm = 0; ne = 0; nr = 0; multi = 0;
    for (int c = 0; c < 24; c++) begin
      nm += 32'(po_money_one);
      ne += 32'(po_err);
      nr += 32'(po_money_half) + 32'(po_refund_half) + 32'(po_refund_one);
      if (n_out() > 1) multi++;
      drv(0, (c < 12), 0, (c < 12), 0);
      tick();
    end
    chk("t5_money", nm, 19);
    chk("t5_err", ne, 5);
    chk("t5_sum", nm + ne, 24);
    chk("t5_other", nr, 0);
    chk("t5_multi", multi, 0);
    chk("t5_stock", po_stock, 2);
    chk("t5_credit", po_credit, 2);

    // Refill on the same cycle as a sale, then refill in VEND.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drv(0, 1, 0, 0, 0);
      tick();
    end
    drv(0, 0, 0, 0, 1);
    tick();
    chk("t7_one", po_money_one, 1);
    chk("t7_credit", po_credit, 0);
    chk("t7_stock", po_stock, 7);
    chk("t7_sold", po_sold_out, 0);
    drv(0, 0, 0, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("t7_refill_stock", po_stock, 8);
    chk("t7_refill_outs", n_out(), 0);

    // Exhaust stock with 25 A one-yuan coins.
    do_reset();
    nm = 0; nr = 0;
    for (int c = 0; c < 28; c++) begin
      nm += 32'(po_money_one);
      nr += 32'(po_refund_one);
      if (c == 24) begin
        chk("t3_c24_stock", po_stock, 1);
        chk("t3_c24_sold", po_sold_out, 0);
      end
      if (c == 25) begin
        chk("t3_c25_one", po_money_one, 1);
        chk("t3_c25_stock", po_stock, 0);
        chk("t3_c25_sold", po_sold_out, 1);
        chk("t3_c25_credit", po_credit, 0);
      end
      if (c == 26) begin
        chk("t3_c26_refund", po_refund_one, 1);
        chk("t3_c26_outs", n_out(), 1);
        chk("t3_c26_src", po_src, 0);
        chk("t3_c26_sold", po_sold_out, 1);
      end
      if (c == 27) chk("t3_c27_outs", n_out(), 0);
      drv(0, (c < 25), 0, 0, 0);
      tick();
    end
    chk("t3_money_cnt", nm, 24);
    chk("t3_refund_cnt", nr, 1);

    // In REFUND: queue coins, refill, then reset mid-stream.
    drv(1, 0, 0, 1, 0);
    tick();
    drv(0, 1, 1, 0, 0);
    tick();
    chk("t6_d2_refund_one", po_refund_one, 1);
    chk("t6_d2_src", po_src, 1);
    chk("t6_d2_outs", n_out(), 1);
    drv(0, 0, 0, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0);
    chk("t6_d3_refund_half", po_refund_half, 1);
    chk("t6_d3_src", po_src, 0);
    chk("t6_d3_stock", po_stock, 8);
    chk("t6_d3_sold", po_sold_out, 0);
    tick();
    chk("t6_d4_half", po_money_half, 1);
    chk("t6_d4_outs", n_out(), 1);
    chk("t6_d4_src", po_src, 1);
    chk("t6_d4_credit", po_credit, 1);
    drv(0, 1, 0, 0, 0);
    tick();
    chk("t6_d5_one", po_money_one, 1);
    chk("t6_d5_src", po_src, 0);
    chk("t6_d5_credit", po_credit, 3);
    drv(0, 1, 0, 0, 0);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", n_out(), 0);
    chk("t6_rst_err", po_err, 0);
    chk("t6_rst_credit", po_credit, 0);
    chk("t6_rst_stock", po_stock, 8);
    chk("t6_rst_sold", po_sold_out, 0);
    drv(0, 0, 0, 0, 0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    nm = 0;
    for (int c = 0; c < 5; c++) begin
      nm += n_out() + 32'(po_err);
      tick();
    end
    chk("t6_post_rst_pulses", nm, 0);
    chk("t6_post_rst_credit", po_credit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_coin_scheduler.md
# vend_coin_scheduler

Front-end controller for the cola vending FSM. It accepts coin pulses from two independent coin slots (A and B) and buffers each slot in a small FIFO. It arbitrates round-robin and feeds the vending FSM at most one coin per cycle on its `pi_money_half`/`pi_money_one` inputs. It also tracks purchase credit and cola stock, and once stock reaches zero it diverts all queued and new coins to refund outputs until a refill.

## Interface

Parameters:
- `DEPTH`, default 4: entries per slot FIFO. Power of two, ≥2.
- `STOCK_INIT`, default 8: stock loaded at reset and on refill. Range 1..255.
- `PRICE`, default 5: price in half-yuan units. Range 2..7.

Ports:
- `sys_clk`, in, 1: clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `pi_a_half`, in, 1: slot A 0.5-yuan coin, one-cycle pulse.
- `pi_a_one`, in, 1: slot A 1-yuan coin, one-cycle pulse.
- `pi_b_half`, in, 1: slot B 0.5-yuan coin, one-cycle pulse.
- `pi_b_one`, in, 1: slot B 1-yuan coin, one-cycle pulse.
- `pi_refill`, in, 1: one-cycle pulse; reload stock.
- `po_money_half`, out, 1: to vending FSM; 0.5-yuan coin pulse.
- `po_money_one`, out, 1: to vending FSM; 1-yuan coin pulse.
- `po_refund_half`, out, 1: refund 0.5-yuan pulse.
- `po_refund_one`, out, 1: refund 1-yuan pulse.
- `po_src`, out, 1: slot of the coin currently on any money/refund output (0=A, 1=B).
- `po_err`, out, 1: one-cycle pulse on an illegal or dropped coin.
- `po_credit`, out, 3: accumulated credit in half-yuan units.
- `po_stock`, out, 8: remaining colas.
- `po_sold_out`, out, 1: high in state REFUND.

## Operation

- **Enqueue.** Each slot has a FIFO of 1-bit entries (0=half, 1=one).
  - A slot with exactly one of half/one high enqueues that coin.
  - A slot with both high enqueues nothing and raises `po_err`.
  - A coin is dropped, with `po_err`, only if its FIFO holds DEPTH entries and is not popped in the same cycle. Enqueue plus pop on a full FIFO is legal.
  - The `po_err` pulses from both slots OR together.
- **Arbitration.** A pointer `last` records the slot served most recently; reset value is B, so A is served first.
  - Each cycle, if either FIFO is non-empty, pop one coin.
  - If both are non-empty, serve the slot ≠ `last`; otherwise serve the non-empty one.
  - Update `last` to the slot served.
- **State VEND** (reset state):
  - The popped coin drives `po_money_half` or `po_money_one`.
  - credit += 1 (half) or 2 (one).
  - If the new credit is ≥ PRICE, a sale occurs: credit := 0 and stock -= 1. Excess change is the vending FSM's responsibility.
  - If the stock becomes 0, go to REFUND.
- **State REFUND:**
  - The popped coin drives `po_refund_half` or `po_refund_one`.
  - Credit is unchanged (it is 0).
  - Enqueue continues as normal.
  - `pi_refill` sets stock := STOCK_INIT and returns to VEND; coins popped from the next cycle on go to the vending FSM.
- **Refill in VEND.** `pi_refill` sets stock := STOCK_INIT.
- **Refill on the same cycle as a sale.** Stock := STOCK_INIT−1 and the state stays VEND.
- **Output exclusivity.** At most one of the four money/refund outputs is high in any cycle.

## Timing

- All outputs are registered.
- **Reset values:**
  - all pulse outputs, `po_src`, and `po_credit` = 0;
  - `po_stock` = STOCK_INIT;
  - `po_sold_out` = 0;
  - FIFOs empty;
  - state VEND.
- **Latency.** A coin pulse high in cycle k is written at the end of k. With no contention it is popped at the end of k+1, and its money/refund output is high for exactly cycle k+2.
- **Status timing.** `po_credit`, `po_stock`, and `po_sold_out` update in the same cycle as the corresponding money output.
- `po_err` is high in cycle k+1 for an offending pulse in cycle k.
- **Throughput.** One coin per cycle total across both slots, so a sustained 2 coins/cycle overflows.
- **Reset mid-operation.** Asserting reset mid-operation immediately discards queued coins, credit and pending pulses. No output pulse may appear after reset assertion.

## Test plan

- Coin on `pi_a_one` at cycle 0, idle otherwise → `po_money_one` high only in cycle 2, `po_src`=0, `po_credit`=2, `po_stock`=8.
- `pi_a_half` and `pi_b_one` pulsed together in cycles 0–3 → outputs in cycles 2–9 alternate A-half, B-one, and so on. Each has the correct `po_src`, with one output per cycle and none dropped.
- STOCK_INIT=1, five `pi_a_half` pulses one per cycle → the 5th `po_money_half` coincides with `po_stock`=0 and `po_sold_out`=1. A 6th coin appears as `po_refund_half` with no `po_money_*` pulse.
- `pi_a_half` and `pi_a_one` high in the same cycle → `po_err` one cycle later, no output, FIFO stays empty.
- DEPTH=4, both slots pulse `one` every cycle for 12 cycles → count of `po_money_one` + `po_err` pulses = 24, at least one `po_err`, and no cycle with two outputs high.
- In REFUND with 3 coins queued, pulse `pi_refill` → stock reloads to 8, `po_sold_out`=0, and the remaining queued coins exit on `po_money_*`. Then assert reset mid-stream → all outputs 0, `po_stock`=8.
